// File: rtl/arb_mux_pkg.sv
// Shared types and constants for the arb_mux arbiting multiplexer.
package arb_mux_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_LOCK
  } arb_state_e;

  localparam logic ARB_MODE_RR  = 1'b0;
  localparam logic ARB_MODE_FIX = 1'b1;

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping mod N.
module arb_mux_rr_pick #(
  parameter int unsigned N     = 8,
  parameter int unsigned WIDTH = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [WIDTH-1:0] ptr,
  output logic             found,
  output logic [WIDTH-1:0] idx
);

  always_comb begin
    int unsigned k;
    k     = 0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr) + i) % N;
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = k[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel registered arbiting mux with valid/ready handshake and per-packet grant lock.
// Optional parity output enabled by defining ARB_MUX_PARITY_EN.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int unsigned M     = 8,
  parameter int unsigned N     = 8,
  parameter int unsigned WIDTH = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*M-1:0]   pdata,
  input  logic [N-1:0]     in_valid,
  input  logic [N-1:0]     in_last,
  output logic [N-1:0]     in_ready,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] s,
  output logic [M-1:0]     data_o,
  output logic             valid_o,
  output logic             last_o,
  output logic [WIDTH-1:0] sel_o,
`ifdef ARB_MUX_PARITY_EN
  output logic             parity_o,
`endif
  input  logic             ready_i
);

  arb_state_e       state_q, state_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic             mode_q, mode_d;
  logic [M-1:0]     data_q;
  logic             valid_q, last_q;
  logic [WIDTH-1:0] sel_q;

  logic             rr_found;
  logic [WIDTH-1:0] rr_idx;
  logic             fix_found;
  logic             can_load;
  logic             accept;
  logic [M-1:0]     grant_data;

  arb_mux_rr_pick #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_rr_pick (
    .req   (in_valid),
    .ptr   (rr_ptr_q),
    .found (rr_found),
    .idx   (rr_idx)
  );

  // Out-of-range fixed selects never produce a candidate.
  always_comb begin
    fix_found = 1'b0;
    if (32'(s) < N) fix_found = in_valid[s];
  end

  assign can_load   = !valid_q || ready_i;
  assign accept     = (state_q == ARB_LOCK) && can_load && in_valid[grant_q];
  assign grant_data = pdata[M*grant_q +: M];

  always_comb begin
    in_ready = '0;
    if (state_q == ARB_LOCK) in_ready[grant_q] = can_load;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    mode_d   = mode_q;
    unique case (state_q)
      ARB_IDLE: begin
        mode_d = mode_i;
        if (mode_i == ARB_MODE_FIX) begin
          if (fix_found) begin
            grant_d = s;
            state_d = ARB_LOCK;
          end
        end else if (rr_found) begin
          grant_d = rr_idx;
          state_d = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        if (accept && in_last[grant_q]) begin
          state_d = ARB_IDLE;
          // Pointer only advances for grants made by the round-robin picker.
          if (mode_q == ARB_MODE_RR) begin
            rr_ptr_d = (32'(grant_q) == N - 1) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      mode_q   <= ARB_MODE_RR;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      mode_q   <= mode_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      sel_q   <= '0;
    end else if (accept) begin
      data_q  <= grant_data;
      valid_q <= 1'b1;
      last_q  <= in_last[grant_q];
      sel_q   <= grant_q;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

`ifdef ARB_MUX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^grant_data;
    end
  end

  assign parity_o = parity_q;
`endif

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign sel_o   = sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Directed self-checking bench for arb_mux (N=6 so an out-of-range fixed select is expressible).
module tb_arb_mux;

  localparam int unsigned M = 8;
  localparam int unsigned N = 6;
  localparam int unsigned W = 3;

  logic           clk;
  logic           rst_n;
  logic [N*M-1:0] pdata;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic           mode_i;
  logic [W-1:0]   s;
  logic [M-1:0]   data_o;
  logic           valid_o;
  logic           last_o;
  logic [W-1:0]   sel_o;
  logic           ready_i;
`ifdef ARB_MUX_PARITY_EN
  logic           parity_o;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] pk [4];

  arb_mux #(
    .M     (M),
    .N     (N),
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pdata    (pdata),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .mode_i   (mode_i),
    .s        (s),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .last_o   (last_o),
    .sel_o    (sel_o),
`ifdef ARB_MUX_PARITY_EN
    .parity_o (parity_o),
`endif
    .ready_i  (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic v, input logic l, input logic [7:0] d);
    in_valid[k]     = v;
    in_last[k]      = l;
    pdata[8*k +: 8] = d;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input int sel, input logic l);
    chk({tag, "_valid"}, 32'(valid_o), 1);
    chk({tag, "_data"}, 32'(data_o), 32'(d));
    chk({tag, "_sel"}, 32'(sel_o), 32'(sel));
    chk({tag, "_last"}, 32'(last_o), 32'(l));
  endtask

  initial begin
    pk[0] = 8'hAA; pk[1] = 8'hBB; pk[2] = 8'hCC; pk[3] = 8'hDD;
    rst_n    = 1'b0;
    pdata    = '0;
    in_valid = '0;
    in_last  = '0;
    mode_i   = 1'b0;
    s        = '0;
    ready_i  = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_data", 32'(data_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_last", 32'(last_o), 0);
    chk("rst_sel", 32'(sel_o), 0);
    chk("rst_ready", 32'(in_ready), 0);
`ifdef ARB_MUX_PARITY_EN
    chk("rst_parity", 32'(parity_o), 0);
`endif
    rst_n = 1'b1;

    // Round-robin over single-beat packets on ch0..3, bubble between packets
    for (int k = 0; k < 4; k++) set_ch(k, 1'b1, 1'b1, 8'(16 + k));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_bubble", 32'(valid_o), 0);
      chk("rr_ready", 32'(in_ready), 32'(1 << (i % 4)));
      @(negedge clk);
      chk_out("rr", 8'(16 + i % 4), i % 4, 1'b1);
      chk("rr_idle_ready", 32'(in_ready), 0);
    end

    // Packet lock: ch2 four beats while ch0/ch1 stay valid; pointer now at 2
    set_ch(3, 1'b0, 1'b0, 8'h00);
    set_ch(2, 1'b1, 1'b0, pk[0]);
    @(negedge clk);
    chk("lock_bubble", 32'(valid_o), 0);
    chk("lock_grant", 32'(in_ready), 'h04);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk_out("lock", pk[b], 2, (b == 3));
      chk("lock_ready", 32'(in_ready), (b < 3) ? 'h04 : 'h00);
      if (b < 3) set_ch(2, 1'b1, (b == 2), pk[b+1]);
    end
    set_ch(2, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("wrap_grant", 32'(in_ready), 'h01);
    @(negedge clk);
    chk_out("wrap", 8'h10, 0, 1'b1);
    in_valid = '0;
    in_last  = '0;

    // Backpressure mid-packet on ch3
    set_ch(3, 1'b1, 1'b0, 8'h31);
    @(negedge clk);
    chk("bp_grant", 32'(in_ready), 'h08);
    @(negedge clk);
    chk_out("bp_first", 8'h31, 3, 1'b0);
    set_ch(3, 1'b1, 1'b0, 8'h32);
    ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_out("bp_hold", 8'h31, 3, 1'b0);
      chk("bp_ready", 32'(in_ready), 0);
    end
    ready_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      chk_out("bp_rel", 8'(8'h32 + b), 3, (b == 2));
      if (b == 0) set_ch(3, 1'b1, 1'b0, 8'h33);
      if (b == 1) set_ch(3, 1'b1, 1'b1, 8'h34);
    end
    set_ch(3, 1'b0, 1'b0, 8'h00);

    // Fixed select s=5; ch4 also valid and would win round-robin (pointer at 4)
    mode_i = 1'b1;
    s      = 3'd5;
    set_ch(4, 1'b1, 1'b1, 8'h44);
    set_ch(5, 1'b1, 1'b1, 8'h55);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      chk("fix_bubble", 32'(valid_o), 0);
      chk("fix_grant", 32'(in_ready), 'h20);
      @(negedge clk);
      chk_out("fix", 8'h55, 5, 1'b1);
    end
    s = 3'd7;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("oor_valid", 32'(valid_o), 0);
      chk("oor_ready", 32'(in_ready), 0);
    end
    mode_i   = 1'b0;
    s        = '0;
    in_valid = '0;
    in_last  = '0;

    // Reset during beat 2 of a 4-beat packet on ch4
    set_ch(4, 1'b1, 1'b0, 8'h41);
    @(negedge clk);
    chk("rstp_grant", 32'(in_ready), 'h10);
    @(negedge clk);
    chk_out("rstp_b1", 8'h41, 4, 1'b0);
    set_ch(4, 1'b1, 1'b0, 8'h42);
    @(negedge clk);
    chk_out("rstp_b2", 8'h42, 4, 1'b0);
    set_ch(4, 1'b1, 1'b0, 8'h43);
    #2 rst_n = 1'b0;
    #1;
    chk("rstp_data", 32'(data_o), 0);
    chk("rstp_valid", 32'(valid_o), 0);
    chk("rstp_sel", 32'(sel_o), 0);
    chk("rstp_ready", 32'(in_ready), 0);
    // ch1 and ch5 compete: a restarted pointer picks ch1, a stale one would pick ch5
    in_valid = '0;
    in_last  = '0;
    set_ch(1, 1'b1, 1'b1, 8'h07);
    set_ch(5, 1'b1, 1'b1, 8'h03);
    @(negedge clk);
    chk("rstp_hold_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_grant", 32'(in_ready), 'h02);
    @(negedge clk);
    chk_out("restart", 8'h07, 1, 1'b1);
`ifdef ARB_MUX_PARITY_EN
    chk("parity_07", 32'(parity_o), 1);
`endif
    set_ch(1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("next_grant", 32'(in_ready), 'h20);
    @(negedge clk);
    chk_out("next", 8'h03, 5, 1'b1);
`ifdef ARB_MUX_PARITY_EN
    chk("parity_03", 32'(parity_o), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
